// File: rtl/board_manager.sv
// 4x4 drop-game board owner: places pieces, scans 10 winning lines, declares win/draw or passes the turn.
// Latency: a legal add enters CHECK at edge N, a win on line k ends the game at edge N+k+1, and the turn returns at edge N+10.
// Backpressure: add is taken only in IDLE; busy flags CHECK/GAME_OVER, and an add in either state is silently dropped.
module board_manager #(
    parameter logic       FIRST_PLAYER = 1'b0,
    parameter logic [4:0] INVALID_POS  = 5'b11111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_game,
    input  logic        add,
    input  logic [4:0]  column_position,
    input  logic [1:0]  c_register,
    output logic [2:0]  counter_0,
    output logic [2:0]  counter_1,
    output logic [2:0]  counter_2,
    output logic [2:0]  counter_3,
    output logic [15:0] board_p1,
    output logic [15:0] board_p2,
    output logic        current_player,
    output logic        busy,
    output logic        move_error,
    output logic [1:0]  winner,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, CHECK, GAME_OVER} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt [4];
    logic [3:0]  scan_idx;
    logic [2:0]  cnt_sel;
    logic [4:0]  exp_pos;
    logic        legal, accept, reject;
    logic [15:0] mover_board, mask, cell_bit;
    logic        line_hit, all_full, last_line;

    function automatic logic [15:0] line_mask(input logic [3:0] idx);
        case (idx)
            4'd0:    line_mask = 16'h000F;
            4'd1:    line_mask = 16'h00F0;
            4'd2:    line_mask = 16'h0F00;
            4'd3:    line_mask = 16'hF000;
            4'd4:    line_mask = 16'h1111;
            4'd5:    line_mask = 16'h2222;
            4'd6:    line_mask = 16'h4444;
            4'd7:    line_mask = 16'h8888;
            4'd8:    line_mask = 16'h8421;
            4'd9:    line_mask = 16'h1248;
            default: line_mask = 16'h0000;
        endcase
    endfunction

    // The drop must land exactly on top of the target column's stack.
    assign cnt_sel   = cnt[c_register];
    assign exp_pos   = {cnt_sel, 2'b00} + {3'b000, c_register};
    assign legal     = (column_position != INVALID_POS) && (cnt_sel != 3'd4) &&
                       (column_position == exp_pos);
    assign accept    = (state == IDLE) && add && !new_game && legal;
    assign reject    = (state == IDLE) && add && !new_game && !legal;
    assign cell_bit  = 16'h0001 << column_position[3:0];

    assign mover_board = current_player ? board_p2 : board_p1;
    assign mask        = line_mask(scan_idx);
    assign line_hit    = (mask != 16'h0000) && ((mover_board & mask) == mask);
    assign all_full    = (cnt[0] == 3'd4) && (cnt[1] == 3'd4) && (cnt[2] == 3'd4) && (cnt[3] == 3'd4);
    assign last_line   = (scan_idx == 4'd9);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (new_game) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (accept) state_nxt = CHECK;
                CHECK: begin
                    // A hit on the final line wins even when the board is full.
                    if (line_hit)       state_nxt = GAME_OVER;
                    else if (last_line) state_nxt = all_full ? GAME_OVER : IDLE;
                end
                GAME_OVER: state_nxt = GAME_OVER;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        game_over = (state == GAME_OVER);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            board_p1       <= 16'h0000;
            board_p2       <= 16'h0000;
            for (int i = 0; i < 4; i++) cnt[i] <= 3'd0;
            scan_idx       <= 4'd0;
            current_player <= FIRST_PLAYER;
            winner         <= 2'b00;
            move_error     <= 1'b0;
        end else if (new_game) begin
            board_p1       <= 16'h0000;
            board_p2       <= 16'h0000;
            for (int i = 0; i < 4; i++) cnt[i] <= 3'd0;
            scan_idx       <= 4'd0;
            current_player <= FIRST_PLAYER;
            winner         <= 2'b00;
            move_error     <= 1'b0;
        end else begin
            move_error <= reject;
            if (accept) begin
                if (current_player) board_p2 <= board_p2 | cell_bit;
                else                board_p1 <= board_p1 | cell_bit;
                cnt[c_register] <= cnt_sel + 3'd1;
                scan_idx        <= 4'd0;
            end
            if (state == CHECK) begin
                scan_idx <= scan_idx + 4'd1;
                if (line_hit)       winner <= current_player ? 2'b10 : 2'b01;
                else if (last_line) begin
                    if (all_full) winner <= 2'b11;
                    else          current_player <= ~current_player;
                end
            end
        end
    end

    assign counter_0 = cnt[0];
    assign counter_1 = cnt[1];
    assign counter_2 = cnt[2];
    assign counter_3 = cnt[3];

endmodule

// File: tb/tb_board_manager.sv
// Directed bench for board_manager: legal/illegal drops, win, draw, busy drops, async reset.
module tb_board_manager;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        new_game;
    logic        add;
    logic [4:0]  column_position;
    logic [1:0]  c_register;
    logic [2:0]  counter_0, counter_1, counter_2, counter_3;
    logic [15:0] board_p1, board_p2;
    logic        current_player, busy, move_error, game_over;
    logic [1:0]  winner;

    int checks = 0;
    int errors = 0;

    board_manager #(.FIRST_PLAYER(1'b0), .INVALID_POS(5'b11111)) dut (
        .clk(clk), .reset_n(reset_n), .new_game(new_game), .add(add),
        .column_position(column_position), .c_register(c_register),
        .counter_0(counter_0), .counter_1(counter_1), .counter_2(counter_2), .counter_3(counter_3),
        .board_p1(board_p1), .board_p2(board_p2), .current_player(current_player),
        .busy(busy), .move_error(move_error), .winner(winner), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents one add for exactly one rising edge; returns at the negedge after it.
    task automatic do_add(input logic [1:0] c, input logic [4:0] pos);
        @(negedge clk);
        add = 1'b1; c_register = c; column_position = pos;
        @(negedge clk);
        add = 1'b0; c_register = 2'd0; column_position = 5'd0;
    endtask

    task automatic do_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("idle_reached", busy, 0);
    endtask

    task automatic wait_over(output int cyc);
        cyc = 0;
        while (!game_over && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        chk("over_reached", game_over, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_brd1"}, board_p1, 0);
        chk({tag, "_brd2"}, board_p2, 0);
        chk({tag, "_cnts"}, {counter_0, counter_1, counter_2, counter_3}, 0);
        chk({tag, "_player"}, current_player, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_merr"}, move_error, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_over"}, game_over, 0);
    endtask

    initial begin
        int cyc;
        logic [1:0] ord_even [4];
        logic [1:0] ord_odd  [4];
        logic [1:0] win_c    [6];
        logic [4:0] win_p    [6];

        reset_n = 1'b0; new_game = 1'b0; add = 1'b0;
        column_position = 5'd0; c_register = 2'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // First drop: P1 at cell 0, busy for exactly 10 cycles.
        do_add(2'd0, 5'd0);
        chk("t1_brd1", board_p1, 16'h0001);
        chk("t1_cnt0", counter_0, 1);
        chk("t1_busy", busy, 1);
        wait_idle(cyc);
        chk("t1_busy_cycles", cyc, 10);
        chk("t1_player", current_player, 1);
        chk("t1_winner", winner, 0);

        // Remaining alternating drops: P1 stacks column 0 and wins on line index 4.
        win_c = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        win_p = '{5'd1, 5'd4, 5'd5, 5'd8, 5'd9, 5'd12};
        for (int i = 0; i < 6; i++) begin
            do_add(win_c[i], win_p[i]);
            if (i < 5) wait_idle(cyc);
        end
        wait_over(cyc);
        chk("win_latency", cyc, 5);
        chk("win_winner", winner, 2'b01);
        chk("win_brd1", board_p1, 16'h1111);
        chk("win_brd2", board_p2, 16'h0222);
        chk("win_player", current_player, 0);
        do_add(2'd2, 5'd2);
        chk("over_add_merr", move_error, 0);
        chk("over_add_cnt2", counter_2, 0);
        chk("over_add_brd1", board_p1, 16'h1111);
        chk("over_hold", game_over, 1);

        do_new_game();
        chk_reset_vals("ng1");

        // Column 2 legality, plus an add presented mid-CHECK.
        do_add(2'd2, 5'd2);
        do_add(2'd3, 5'd3);
        chk("busy_add_merr", move_error, 0);
        chk("busy_add_cnt3", counter_3, 0);
        chk("busy_add_brd", board_p1 | board_p2, 16'h0004);
        wait_idle(cyc);
        do_add(2'd2, 5'd2);
        chk("wrongpos_merr", move_error, 1);
        chk("wrongpos_cnt2", counter_2, 1);
        @(negedge clk);
        chk("merr_one_cycle", move_error, 0);
        do_add(2'd2, 5'd6);
        chk("pos6_cnt2", counter_2, 2);
        chk("pos6_merr", move_error, 0);
        wait_idle(cyc);
        do_add(2'd2, 5'd10);
        wait_idle(cyc);
        do_add(2'd2, 5'd14);
        wait_idle(cyc);
        chk("col2_full", counter_2, 4);
        do_add(2'd2, 5'b11111);
        chk("invalid_merr", move_error, 1);
        chk("invalid_cnt2", counter_2, 4);
        do_add(2'd2, 5'd18);
        chk("full_merr", move_error, 1);
        chk("full_cnt2", counter_2, 4);
        chk("col2_brd1", board_p1, 16'h0404);
        chk("col2_brd2", board_p2, 16'h4040);
        chk("col2_player", current_player, 0);

        // Draw: rows alternate 1122 / 2211, filled row by row.
        do_new_game();
        ord_even = '{2'd0, 2'd2, 2'd1, 2'd3};
        ord_odd  = '{2'd2, 2'd0, 2'd3, 2'd1};
        for (int i = 0; i < 16; i++) begin
            logic [1:0] c;
            c = ((i / 4) % 2 == 0) ? ord_even[i % 4] : ord_odd[i % 4];
            do_add(c, 5'((i / 4) * 4 + c));
            if (i < 15) begin
                wait_idle(cyc);
                chk("draw_no_winner", winner, 0);
            end
        end
        wait_over(cyc);
        chk("draw_latency", cyc, 10);
        chk("draw_winner", winner, 2'b11);
        chk("draw_brd1", board_p1, 16'hC3C3);
        chk("draw_brd2", board_p2, 16'h3C3C);
        chk("draw_cnts", {counter_0, counter_1, counter_2, counter_3}, 12'h924);
        do_new_game();
        chk_reset_vals("ng2");

        // Asynchronous reset in the middle of CHECK.
        do_add(2'd0, 5'd0);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        do_add(2'd1, 5'd1);
        chk("post_rst_cnt1", counter_1, 1);
        chk("post_rst_brd1", board_p1, 16'h0002);
        wait_idle(cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/board_manager.md
Name: board_manager

Overview:
- Receiving end of the drop interface: consumes `add`, `column_position` and `c_register` from the column calculation stage.
- Owns the 4x4 board state and feeds the per-column fill counters back to that stage.
- Places the current player's piece, then sequentially scans all 10 winning lines (4 rows, 4 columns, 2 diagonals).
- Declares win or draw, or hands the turn to the other player.

Parameters:
- FIRST_PLAYER, 0, player who moves first after reset or new_game (0 = P1, 1 = P2).
- INVALID_POS, 5'b11111, column_position code meaning "no legal drop".

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- new_game  input  1  synchronous clear of board and game state; has priority over add.
- add  input  1  one-cycle request to place a piece.
- column_position  input  5  target cell index, row*4+col, row 0 = bottom; INVALID_POS = none.
- c_register  input  2  target column 0..3.
- counter_0  output  3  pieces in column 0 (0..4; 4 = full).
- counter_1  output  3  pieces in column 1.
- counter_2  output  3  pieces in column 2.
- counter_3  output  3  pieces in column 3.
- board_p1  output  16  bit i set = P1 piece in cell i.
- board_p2  output  16  bit i set = P2 piece in cell i.
- current_player  output  1  0 = P1, 1 = P2; player whose move is expected.
- busy  output  1  high whenever state != IDLE.
- move_error  output  1  one-cycle pulse when an add is rejected.
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw.
- game_over  output  1  high in GAME_OVER.

Behaviour:
- Reset (reset_n low, async):
  - counters = 0, board_p1 = board_p2 = 0, current_player = FIRST_PLAYER.
  - busy = 0, move_error = 0, winner = 00, game_over = 0, state = IDLE, scan index = 0.
- new_game (sync, any state): same values as reset, applied at the next edge; any add in that cycle is ignored.
- States: IDLE, CHECK, GAME_OVER.
- IDLE, add = 1: the add is legal only if all of these hold:
  - column_position != INVALID_POS;
  - counter_c != 4, where c = c_register;
  - column_position == counter_c*4 + c, computed 5-bit.
- Legal add, at the same edge:
  - set the current player's bit at column_position;
  - counter_c increments by 1;
  - scan index = 0;
  - state goes to CHECK.
- Illegal add: no state change; move_error pulses high for one cycle.
- add outside IDLE: ignored, no move_error.
- CHECK: evaluate one line per cycle against the moving player's board, fixed order:
  - index 0..3 = rows 0..3 (cells r*4..r*4+3);
  - index 4..7 = columns 0..3 (cells c, c+4, c+8, c+12);
  - index 8 = diagonal {0,5,10,15};
  - index 9 = diagonal {3,6,9,12}.
- Line fully owned (all 4 bits set):
  - winner = 01 or 10 for the moving player;
  - game_over = 1;
  - state goes to GAME_OVER;
  - current_player is not toggled.
- Index 9 evaluated with no match:
  - if all counters == 4: winner = 11, game_over = 1, state goes to GAME_OVER;
  - otherwise current_player toggles and state returns to IDLE.
- A win on the last cell takes precedence over draw.
- Latency: a legal add accepted at edge N → busy rises after N.
  - Winning line at index k: GAME_OVER from edge N+k+1.
  - No win: IDLE again after edge N+10; the next add is accepted at edge N+11 at the earliest.
- GAME_OVER: board, counters and winner hold; only new_game or reset leaves it.
- Counters saturate at 4 and never wrap; board bits are never cleared except by reset or new_game.
- board_p1 & board_p2 == 0 always.

Test Plan:
- Reset, then add with c_register=0, column_position=0 → board_p1=0x0001, counter_0=1, busy high for 10 cycles, then current_player=1, winner=00.
- Alternate legal drops P1:col0, P2:col1, P1:col0, P2:col1, P1:col0, P2:col1, P1:col0 → after the 7th drop, column line index 4 matches: winner=01, game_over=1, 5 cycles after the accepting edge; further adds ignored.
- Fill column 2 to counter_2=4, then add with c_register=2, column_position=5'b11111 → move_error pulse, no state change; also add with column_position=6 while counter_2=1 (expected 6): accepted. Same with column_position=2: move_error.
- add asserted while busy (mid-CHECK) → ignored, no move_error, counters unchanged.
- Drop sequence filling all 16 cells with no 4-in-line → winner=11, game_over=1 after the final scan; new_game → all outputs back to reset values, current_player=FIRST_PLAYER.
- Assert reset_n low mid-CHECK → outputs cleared immediately (asynchronously), state IDLE on release.
